shift_add_mult_ctrl: RTL
========================

Name: shift_add_mult_ctrl

Overview:
Sequential shift-and-add multiplier controller that time-shares one external N-bit ripple adder (ports a, b, cin, sum, cout) to form an unsigned N×N → 2N product.
- Drives the adder operands each cycle.
- Captures sum/cout back into a shifting accumulator.
- Exposes a start/busy/done handshake to the surrounding multiplier top level.

Parameters:
N, 6, operand width in bits. Legal for N ≥ 2. The iteration counter is $clog2(N+1) bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
start  input  1  request a multiply; sampled only in IDLE
mcand  input  N  multiplicand; captured on the accepted start edge
mplier  input  N  multiplier; captured on the accepted start edge
add_a  output  N  adder operand a = accumulator high half
add_b  output  N  adder operand b = mcand_reg when acc[0]=1, else 0
add_cin  output  1  adder carry-in; tied 0
add_sum  input  N  adder sum result
add_cout  input  1  adder carry-out
product  output  2N  result; valid while done=1 and held until the next accepted start
busy  output  1  1 in ADD and DONE states
done  output  1  one-cycle pulse; product valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, mcand_reg=0, count=0, product=0, busy=0, done=0. add_a and add_b follow the cleared registers, so both are 0.
- Registers:
  - acc: 2N bits, {hi[N-1:0], lo[N-1:0]}.
  - mcand_reg: N bits.
  - count.
  - state ∈ {IDLE, ADD, DONE}.
- IDLE:
  - busy=0, done=0.
  - On a rising edge with start=1: mcand_reg←mcand, acc←{0, mplier}, count←0, state←ADD.
  - If start=0, hold.
- ADD, one iteration per edge:
  - The combinational adder result is used in the same cycle.
  - Let t = acc[0] ? {add_cout, add_sum} : {1'b0, hi}. This is N+1 bits.
  - acc ← {t, lo} >> 1. The dropped LSB is the consumed multiplier bit.
  - count ← count+1.
  - When count == N-1 on the edge: state←DONE, product←new acc value.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - Next edge: state←IDLE.
- Latency: start accepted at edge k; done=1 in the cycle after edge k+N. Total N+1 cycles from the start edge to the done cycle; start-to-start throughput is N+2 cycles.
- start while in ADD or DONE is ignored; it is not queued. The requester must re-assert start in IDLE.
- Changes to mcand/mplier after acceptance have no effect.
- product is not updated during ADD. It holds the previous result until the DONE transition writes the new one.
- Carry: add_cout is shifted into hi[N-1], so no overflow is possible. The maximum result (2^N−1)^2 fits in 2N bits.
- Reset asserted mid-operation aborts immediately to the reset values. No done is issued.
- The controller never depends on add_sum/add_cout outside ADD.

Optional Feature:
ZERO_SKIP_EN
- Defined: on an accepted start with mcand==0 or mplier==0, go directly IDLE→DONE with product←0. done appears in the cycle after the start edge, a 1-cycle latency. No ADD cycles are performed.
- Not defined: zero operands take the full N-iteration path, with product=0 after N+1 cycles.
- The handshake and reset behaviour are identical in both builds.

Test Plan:
1. N=6, reset, then start with mcand=5, mplier=3 → done pulses exactly 7 cycles after the start edge, product=15 (0x00F); busy=1 across those cycles.
2. mcand=63, mplier=63 → product=3969 (0xF81); exercises add_cout capture into hi[N-1].
3. Start accepted (mcand=10, mplier=9), then start re-pulsed with mcand=1, mplier=1 mid-ADD → ignored; product=90, and a single done pulse.
4. rst_n pulled low during the 3rd ADD cycle → product=0, busy=0, done never asserts. Next start with 7×8 → product=56.
5. mcand=0, mplier=45 → product=0. Latency is 1 cycle with ZERO_SKIP_EN and 7 cycles without it.
6. Back-to-back: start held high continuously with 2×3 then 4×5 (operands changed after the first done) → first done gives product=6; second start accepted in IDLE; second done gives product=20; done pulses 8 cycles apart.

Source files
------------

// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add multiplier controller driving one external N-bit adder.
// Optional build macro ZERO_SKIP_EN: zero operands bypass the iterations.
module shift_add_mult_ctrl #(
  parameter int N = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     mcand,
  input  logic [N-1:0]     mplier,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_cin,
  input  logic [N-1:0]     add_sum,
  input  logic             add_cout,
  output logic [2*N-1:0]   product,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mcand_reg;
  logic [CW-1:0]  count;
  logic [N:0]     step_hi;
  logic [2*N-1:0] acc_next;

  assign add_a   = acc[2*N-1:N];
  assign add_b   = acc[0] ? mcand_reg : '0;
  assign add_cin = 1'b0;

  // Adder carry lands in hi[N-1] after the shift, so the product never overflows.
  always_comb begin
    step_hi  = acc[0] ? {add_cout, add_sum} : {1'b0, acc[2*N-1:N]};
    acc_next = {step_hi, acc[N-1:1]};
  end

  assign busy = (state == ADD) || (state == DONE);
  assign done = (state == DONE);

  // NOTE: state registers use non-blocking assignments so every update in the
  // block sees the pre-edge values, matching how the flops actually behave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand_reg <= '0;
      count     <= '0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand_reg <= mcand;
            acc       <= {{N{1'b0}}, mplier};
            count     <= '0;
`ifdef ZERO_SKIP_EN
            if ((mcand == '0) || (mplier == '0)) begin
              product <= '0;
              state   <= DONE;
            end else begin
              state   <= ADD;
            end
`else
            state     <= ADD;
`endif
          end
        end
        ADD: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == CW'(N - 1)) begin
            product <= acc_next;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
